// File: rtl/interval_timer_bank.sv
`default_nettype none
// interval_timer_bank: programmable interval slots with 1-cycle readback and a
// start/abort/tick countdown timer that pulses expired after exactly N ticks.
module interval_timer_bank #(
  parameter int NUM_INTERVALS = 3,
  parameter int TIME_WIDTH    = 4,
  parameter int SEL_WIDTH     = 2,
  parameter logic [NUM_INTERVALS*TIME_WIDTH-1:0] DEFAULT_VALUES = 12'h236
) (
  input  logic                  clk,
  input  logic                  global_reset_n,
  input  logic                  reprogram,
  input  logic [SEL_WIDTH-1:0]  time_param_selector,
  input  logic [TIME_WIDTH-1:0] input_time_value,
  output logic                  prog_error,
  input  logic [SEL_WIDTH-1:0]  fsm_requested_interval,
  output logic [TIME_WIDTH-1:0] output_time_value,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  tick,
  output logic                  busy,
  output logic [TIME_WIDTH-1:0] remaining,
  output logic                  expired
);

  localparam logic [SEL_WIDTH:0] NUM_SLOTS = (SEL_WIDTH+1)'(NUM_INTERVALS);

  typedef enum logic [0:0] {IDLE = 1'b0, COUNT = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [TIME_WIDTH-1:0] slot_q [NUM_INTERVALS];
  logic [TIME_WIDTH-1:0] sel_value;
  logic [TIME_WIDTH-1:0] remaining_d;
  logic                  expired_d;
  logic                  write_in_range;
  logic [1:0]            rst_sync_q;
  logic                  rst_n;

  // Assertion reaches every flop at once; release is aligned to clk.
  always_ff @(posedge clk or negedge global_reset_n) begin
    if (!global_reset_n) rst_sync_q <= 2'b00;
    else                 rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  assign write_in_range = ({1'b0, time_param_selector} < NUM_SLOTS);

  always_comb begin
    sel_value = '1;
    for (int i = 0; i < NUM_INTERVALS; i++) begin
      if (fsm_requested_interval == SEL_WIDTH'(i)) sel_value = slot_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_INTERVALS; i++)
        slot_q[i] <= DEFAULT_VALUES[i*TIME_WIDTH +: TIME_WIDTH];
      output_time_value <= '0;
      prog_error        <= 1'b0;
    end else begin
      // A zero write restores the slot default so a slot can never hold 0.
      for (int i = 0; i < NUM_INTERVALS; i++) begin
        if (reprogram && time_param_selector == SEL_WIDTH'(i))
          slot_q[i] <= (input_time_value == '0) ?
                       DEFAULT_VALUES[i*TIME_WIDTH +: TIME_WIDTH] : input_time_value;
      end
      output_time_value <= sel_value;
      prog_error        <= reprogram && !write_in_range;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      remaining <= '0;
      expired   <= 1'b0;
    end else begin
      state_q   <= state_d;
      remaining <= remaining_d;
      expired   <= expired_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining;
    expired_d   = 1'b0;
    if (abort) begin
      state_d     = IDLE;
      remaining_d = '0;
    end else if (start) begin
      state_d     = COUNT;
      remaining_d = sel_value;
    end else if (state_q == COUNT && tick) begin
      if (remaining > TIME_WIDTH'(1)) begin
        remaining_d = remaining - TIME_WIDTH'(1);
      end else begin
        remaining_d = '0;
        state_d     = IDLE;
        expired_d   = 1'b1;
      end
    end
  end

  assign busy = (state_q == COUNT);

endmodule
`default_nettype wire

// File: tb/tb_interval_timer_bank.sv
`default_nettype none
// Directed self-checking bench for interval_timer_bank.
module tb_interval_timer_bank;

  logic       clk = 1'b0;
  logic       global_reset_n = 1'b0;
  logic       reprogram = 1'b0;
  logic [1:0] time_param_selector = '0;
  logic [3:0] input_time_value = '0;
  logic       prog_error;
  logic [1:0] fsm_requested_interval = '0;
  logic [3:0] output_time_value;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       tick = 1'b0;
  logic       busy;
  logic [3:0] remaining;
  logic       expired;

  int pass_cnt = 0;
  int total_cnt = 0;

  interval_timer_bank dut (
    .clk                    (clk),
    .global_reset_n         (global_reset_n),
    .reprogram              (reprogram),
    .time_param_selector    (time_param_selector),
    .input_time_value       (input_time_value),
    .prog_error             (prog_error),
    .fsm_requested_interval (fsm_requested_interval),
    .output_time_value      (output_time_value),
    .start                  (start),
    .abort                  (abort),
    .tick                   (tick),
    .busy                   (busy),
    .remaining              (remaining),
    .expired                (expired)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    global_reset_n = 1'b0;
    repeat (2) step();
    total_cnt++;
    if ({output_time_value, remaining, busy, expired, prog_error} !== 11'd0) $display("FAIL reset_outputs: got otv=%0d rem=%0d busy=%b exp=%b perr=%b want all 0", output_time_value, remaining, busy, expired, prog_error);
    else pass_cnt++;
    global_reset_n = 1'b1;
    repeat (4) step();
    for (int i = 0; i < 3; i++) begin
      logic [3:0] exp_v;
      exp_v = (i == 0) ? 4'd6 : (i == 1) ? 4'd3 : 4'd2;
      fsm_requested_interval = 2'(i);
      step();
      total_cnt++;
      if (output_time_value !== exp_v) $display("FAIL reset_slot%0d: got %0d want %0d", i, output_time_value, exp_v);
      else pass_cnt++;
    end
    total_cnt++;
    if (busy !== 1'b0 || remaining !== 4'd0) $display("FAIL reset_timer: got busy=%b rem=%0d want 0/0", busy, remaining);
    else pass_cnt++;
  endtask

  task automatic test_write();
    fsm_requested_interval = 2'd0;
    reprogram = 1'b1; time_param_selector = 2'd0; input_time_value = 4'd9;
    step();
    reprogram = 1'b0;
    total_cnt++;
    if (output_time_value !== 4'd6) $display("FAIL write_same_cycle_old: got %0d want 6", output_time_value);
    else pass_cnt++;
    step();
    total_cnt++;
    if (output_time_value !== 4'd9) $display("FAIL write_slot0: got %0d want 9", output_time_value);
    else pass_cnt++;
    fsm_requested_interval = 2'd2;
    reprogram = 1'b1; time_param_selector = 2'd2; input_time_value = 4'd7;
    step();
    input_time_value = 4'd0;
    step();
    reprogram = 1'b0;
    total_cnt++;
    if (output_time_value !== 4'd7) $display("FAIL write_slot2_7: got %0d want 7", output_time_value);
    else pass_cnt++;
    step();
    total_cnt++;
    if (output_time_value !== 4'd2) $display("FAIL write_zero_default: got %0d want 2", output_time_value);
    else pass_cnt++;
  endtask

  task automatic test_prog_error();
    reprogram = 1'b1; time_param_selector = 2'd0; input_time_value = 4'd0;
    step();
    total_cnt++;
    if (prog_error !== 1'b0) $display("FAIL perr_inrange: got %b want 0", prog_error);
    else pass_cnt++;
    time_param_selector = 2'd3; input_time_value = 4'd5;
    step();
    reprogram = 1'b0;
    total_cnt++;
    if (prog_error !== 1'b1) $display("FAIL perr_pulse: got %b want 1", prog_error);
    else pass_cnt++;
    step();
    total_cnt++;
    if (prog_error !== 1'b0) $display("FAIL perr_one_cycle: got %b want 0", prog_error);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      logic [3:0] exp_v;
      exp_v = (i == 0) ? 4'd6 : (i == 1) ? 4'd3 : (i == 2) ? 4'd2 : 4'hF;
      fsm_requested_interval = 2'(i);
      step();
      total_cnt++;
      if (output_time_value !== exp_v) $display("FAIL perr_slot%0d: got %0d want %0d", i, output_time_value, exp_v);
      else pass_cnt++;
    end
  endtask

  task automatic test_countdown();
    fsm_requested_interval = 2'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    total_cnt++;
    if (busy !== 1'b1 || remaining !== 4'd3) $display("FAIL cd_start: got busy=%b rem=%0d want 1/3", busy, remaining);
    else pass_cnt++;
    for (int k = 1; k <= 3; k++) begin
      repeat (3) begin
        step();
        total_cnt++;
        if (expired !== 1'b0 || remaining !== 4'(4 - k)) $display("FAIL cd_idle_gap%0d: got exp=%b rem=%0d want 0/%0d", k, expired, remaining, 4 - k);
        else pass_cnt++;
      end
      tick = 1'b1;
      step();
      tick = 1'b0;
      total_cnt++;
      if (remaining !== 4'(3 - k) || busy !== (k < 3) || expired !== (k == 3)) $display("FAIL cd_tick%0d: got rem=%0d busy=%b exp=%b want %0d/%b/%b", k, remaining, busy, expired, 3 - k, k < 3, k == 3);
      else pass_cnt++;
    end
    step();
    total_cnt++;
    if (expired !== 1'b0) $display("FAIL cd_pulse_width: got %b want 0", expired);
    else pass_cnt++;
    tick = 1'b1;
    repeat (2) begin
      step();
      total_cnt++;
      if (expired !== 1'b0 || busy !== 1'b0 || remaining !== 4'd0) $display("FAIL cd_extra_tick: got exp=%b busy=%b rem=%0d want 0/0/0", expired, busy, remaining);
      else pass_cnt++;
    end
    tick = 1'b0;
  endtask

  task automatic test_restart_abort();
    fsm_requested_interval = 2'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    tick = 1'b1;
    repeat (2) step();
    tick = 1'b0;
    total_cnt++;
    if (remaining !== 4'd4) $display("FAIL ra_two_ticks: got %0d want 4", remaining);
    else pass_cnt++;
    fsm_requested_interval = 2'd2;
    start = 1'b1; tick = 1'b1;
    step();
    start = 1'b0; tick = 1'b0;
    total_cnt++;
    if (remaining !== 4'd2 || busy !== 1'b1) $display("FAIL ra_restart: got rem=%0d busy=%b want 2/1", remaining, busy);
    else pass_cnt++;
    tick = 1'b1;
    step();
    tick = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    total_cnt++;
    if (busy !== 1'b0 || remaining !== 4'd0 || expired !== 1'b0) $display("FAIL ra_abort: got busy=%b rem=%0d exp=%b want 0/0/0", busy, remaining, expired);
    else pass_cnt++;
    tick = 1'b1;
    repeat (2) begin
      step();
      total_cnt++;
      if (expired !== 1'b0) $display("FAIL ra_no_expire: got %b want 0", expired);
      else pass_cnt++;
    end
    tick = 1'b0;
  endtask

  task automatic test_collision_and_reset();
    fsm_requested_interval = 2'd0;
    start = 1'b1;
    reprogram = 1'b1; time_param_selector = 2'd0; input_time_value = 4'd4;
    step();
    start = 1'b0; reprogram = 1'b0;
    total_cnt++;
    if (remaining !== 4'd6 || output_time_value !== 4'd6) $display("FAIL col_old_value: got rem=%0d otv=%0d want 6/6", remaining, output_time_value);
    else pass_cnt++;
    start = 1'b1;
    step();
    start = 1'b0;
    total_cnt++;
    if (remaining !== 4'd4) $display("FAIL col_new_value: got %0d want 4", remaining);
    else pass_cnt++;
    tick = 1'b1;
    step();
    tick = 1'b0;
    #2 global_reset_n = 1'b0;
    #1;
    total_cnt++;
    if ({output_time_value, remaining, busy, expired, prog_error} !== 11'd0) $display("FAIL async_reset: got otv=%0d rem=%0d busy=%b exp=%b perr=%b want all 0", output_time_value, remaining, busy, expired, prog_error);
    else pass_cnt++;
    repeat (2) step();
    global_reset_n = 1'b1;
    repeat (4) step();
    total_cnt++;
    if (expired !== 1'b0 || busy !== 1'b0) $display("FAIL reset_no_expire: got exp=%b busy=%b want 0/0", expired, busy);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      logic [3:0] exp_v;
      exp_v = (i == 0) ? 4'd6 : (i == 1) ? 4'd3 : 4'd2;
      fsm_requested_interval = 2'(i);
      step();
      total_cnt++;
      if (output_time_value !== exp_v) $display("FAIL post_reset_slot%0d: got %0d want %0d", i, output_time_value, exp_v);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_prog_error();
    test_countdown();
    test_restart_abort();
    test_collision_and_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/interval_timer_bank.md
Name: interval_timer_bank

Overview:
Parametrised interval store plus countdown timer for the traffic controller. It holds NUM_INTERVALS programmable durations, and the FSM can read any of them back. The FSM can also start a countdown on a selected interval and receives a one-cycle expired pulse when it elapses. It sits between the reprogramming interface and the light-sequencing FSM; the FSM no longer needs an external counter.

Parameters:
NUM_INTERVALS, 3, number of interval slots (1..2**SEL_WIDTH).
TIME_WIDTH, 4, bit width of each interval and of the countdown.
SEL_WIDTH, 2, width of the slot selectors.
DEFAULT_VALUES, 12'h236, packed reset/default values; slot i is at [i*TIME_WIDTH +: TIME_WIDTH]; defaults are slot0=6 (base), slot1=3 (extended), slot2=2 (yellow); width is NUM_INTERVALS*TIME_WIDTH.

Ports:
clk  in  1  system clock, rising edge.
global_reset_n  in  1  asynchronous, active-low reset.
reprogram  in  1  write strobe for interval registers.
time_param_selector  in  SEL_WIDTH  slot to write.
input_time_value  in  TIME_WIDTH  value to write; 0 selects the slot default.
prog_error  out  1  registered one-cycle pulse when a write targets slot >= NUM_INTERVALS.
fsm_requested_interval  in  SEL_WIDTH  slot for readback and timer start.
output_time_value  out  TIME_WIDTH  registered readback of the requested slot.
start  in  1  load and start the countdown from the requested slot.
abort  in  1  stop the countdown without an expired pulse.
tick  in  1  one-cycle time-base enable (prescaler output).
busy  out  1  countdown active.
remaining  out  TIME_WIDTH  current countdown value.
expired  out  1  one-cycle pulse on countdown completion.

Behaviour:
- Reset (async assert, sync release):
  - slot registers = DEFAULT_VALUES.
  - output_time_value = 0, remaining = 0.
  - busy = 0, expired = 0, prog_error = 0.
  - FSM in IDLE.
- Write path: on a clk edge with reprogram=1 and time_param_selector < NUM_INTERVALS:
  - slot <= input_time_value, or the slot's DEFAULT if input_time_value == 0.
  - The write is visible from the next cycle.
- Out-of-range write (selector >= NUM_INTERVALS): no register changes; prog_error=1 for exactly one cycle. This replaces the old behaviour of saturating all slots.
- Readback: output_time_value <= slot[fsm_requested_interval] every cycle, 1-cycle latency, regardless of reprogram.
  - An out-of-range request returns all-ones.
  - A write and a read of the same slot in the same cycle returns the old value; the new value appears one cycle later.
- Timer FSM, states IDLE and COUNT; priority per cycle is abort > start > tick.
  - Any state, abort=1: next IDLE, busy=0, remaining=0, no expired.
  - Any state, start=1 (abort=0): remaining <= current slot value of fsm_requested_interval (all-ones if out of range); next COUNT, busy=1. A start during COUNT restarts from the new value, and a simultaneous tick is ignored.
  - A start that coincides with a write to the same slot loads the pre-write value.
  - COUNT, tick=1, remaining > 1: remaining decrements by 1.
  - COUNT, tick=1, remaining == 1: remaining <= 0; next IDLE; busy=0 and expired=1 on the same edge, for one cycle.
  - Duration is therefore exactly N ticks after start, for a loaded value N.
  - IDLE, tick: no effect.
- Programmed values never reach 0, so a loaded value is >= 1.
- Reprogramming during COUNT does not alter the running count.
- Reset asserted mid-count: immediately IDLE, busy=0, remaining=0, no expired pulse.
- All outputs are registered. Values are unsigned; no arithmetic wraps, because decrement stops at 0.

Test Plan:
1. Reset, then read slots 0/1/2 -> output_time_value 6, 3, 2 one cycle after each request; busy=0, remaining=0.
2. reprogram sel=0 value=9, then read slot 0 -> 9. Then write sel=2 value=0 -> slot2 reads 2 (its default).
3. reprogram sel=3 value=5 -> prog_error high for one cycle; slots still 6/3/2; read slot 3 -> 4'hF.
4. start on slot1 (value 3), then 3 ticks spaced 4 cycles apart -> remaining 3,2,1,0. expired is a single-cycle pulse with busy falling on the same edge as the third tick. No pulse on the extra ticks that follow.
5. start slot0 (value 6), 2 ticks, then start slot2 with tick in the same cycle -> remaining=2, busy stays 1. Then abort during the count -> busy=0, remaining=0, and expired never asserts.
6. start slot0 with a same-cycle write sel=0 value=4 -> remaining=6; the next start loads 4. global_reset_n low mid-count -> all outputs 0 asynchronously and slots return to 6/3/2.
